// File: rtl/touch_coord_reader.sv
// -----------------------------------------------------------------------------
// touch_coord_reader
//
// Periodically reads an X/Y coordinate pair from a resistive touch-screen
// controller (ADS7846-style) over a 24-clock SPI frame per axis.
//
// While the pen is down, one X frame (command 0xD0) and one Y frame
// (command 0x90) are run each time the free-running sample timer wraps.
// The pair is published only if the pen is still down when both frames
// have finished.
//
// Ports
//   clock        sole clock, rising edge
//   reset        synchronous, active-high
//   pen_irq_n    pen-down flag from controller, active low, asynchronous
//   spi_miso     serial data from controller
//   spi_sclk     serial clock, idles low
//   spi_mosi     serial command data to controller
//   spi_cs_n     chip select, active low
//   x_touch      last published X coordinate
//   y_touch      last published Y coordinate
//   touch_valid  one-cycle pulse when a new X/Y pair is published
//   isPressed    synchronised pen-down level
// -----------------------------------------------------------------------------
module touch_coord_reader #(
  parameter int CLK_DIV       = 25,     // clocks per SCLK half-period (>= 2)
  parameter int SAMPLE_PERIOD = 50000   // clocks between conversion-pair starts
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pen_irq_n,
  input  logic        spi_miso,
  output logic        spi_sclk,
  output logic        spi_mosi,
  output logic        spi_cs_n,
  output logic [11:0] x_touch,
  output logic [11:0] y_touch,
  output logic        touch_valid,
  output logic        isPressed
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int TW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;

  localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(SAMPLE_PERIOD - 1);

  localparam logic [7:0] CMD_X = 8'hD0;
  localparam logic [7:0] CMD_Y = 8'h90;

  typedef enum logic [2:0] {
    IDLE,
    CONV_X,
    GAP,
    CONV_Y,
    PUBLISH
  } state_t;

  state_t        state_q,   state_d;
  logic [TW-1:0] timer_q,   timer_d;
  logic          pending_q, pending_d;
  logic [DW-1:0] div_q,     div_d;
  logic          half_q,    half_d;     // 0 = SCLK low half, 1 = high half
  logic [4:0]    period_q,  period_d;   // SCLK period within the frame, 0..23
  logic [11:0]   x_shift_q, x_shift_d;
  logic [11:0]   y_shift_q, y_shift_d;
  logic          sclk_q,    sclk_d;
  logic          mosi_q,    mosi_d;
  logic          cs_n_q,    cs_n_d;
  logic [11:0]   x_q,       x_d;
  logic [11:0]   y_q,       y_d;
  logic          valid_q,   valid_d;
  logic          sync1_q,   sync2_q;

  logic          is_pressed;
  logic          timer_wrap;
  logic          enter_x;
  logic [7:0]    cmd;
  logic [4:0]    period_nxt;

  assign is_pressed = ~sync2_q;
  assign timer_wrap = (timer_q == TIMER_LAST);
  assign cmd        = (state_q == CONV_X) ? CMD_X : CMD_Y;
  assign period_nxt = period_q + 5'd1;

  // Sample timer runs regardless of state; a wrap while a request is already
  // pending simply leaves it pending, so at most one pair is ever queued.
  always_comb begin
    timer_d   = timer_wrap ? '0 : timer_q + TW'(1);
    pending_d = pending_q;
    if (enter_x)    pending_d = 1'b0;
    if (timer_wrap) pending_d = 1'b1;
  end

  // NOTE: every signal assigned in this block gets a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    half_d    = half_q;
    period_d  = period_q;
    x_shift_d = x_shift_q;
    y_shift_d = y_shift_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    cs_n_d    = cs_n_q;
    x_d       = x_q;
    y_d       = y_q;
    valid_d   = 1'b0;
    enter_x   = 1'b0;

    case (state_q)
      IDLE: begin
        cs_n_d = 1'b1;
        sclk_d = 1'b0;
        mosi_d = 1'b0;
        if (is_pressed && pending_q) begin
          state_d   = CONV_X;
          enter_x   = 1'b1;
          div_d     = '0;
          half_d    = 1'b0;
          period_d  = '0;
          cs_n_d    = 1'b0;
          mosi_d    = CMD_X[7];
          x_shift_d = '0;
        end
      end

      CONV_X, CONV_Y: begin
        if (div_q != DIV_LAST) begin
          div_d = div_q + DW'(1);
        end else begin
          div_d = '0;
          if (!half_q) begin
            // End of low half: SCLK rises and the controller's bit is taken.
            half_d = 1'b1;
            sclk_d = 1'b1;
            if (period_q >= 5'd9 && period_q <= 5'd20) begin
              if (state_q == CONV_X) x_shift_d = {x_shift_q[10:0], spi_miso};
              else                   y_shift_d = {y_shift_q[10:0], spi_miso};
            end
          end else begin
            // End of high half: SCLK falls, MOSI moves to the next period.
            half_d = 1'b0;
            sclk_d = 1'b0;
            if (period_q == 5'd23) begin
              period_d = '0;
              cs_n_d   = 1'b1;
              mosi_d   = 1'b0;
              state_d  = (state_q == CONV_X) ? GAP : PUBLISH;
            end else begin
              period_d = period_nxt;
              mosi_d   = (period_nxt < 5'd8) ? cmd[3'd7 - period_nxt[2:0]] : 1'b0;
            end
          end
        end
      end

      GAP: begin
        if (div_q != DIV_LAST) begin
          div_d = div_q + DW'(1);
        end else begin
          state_d   = CONV_Y;
          div_d     = '0;
          half_d    = 1'b0;
          period_d  = '0;
          cs_n_d    = 1'b0;
          mosi_d    = CMD_Y[7];
          y_shift_d = '0;
        end
      end

      PUBLISH: begin
        // Pen-up during the frames is only judged here; a released pen
        // discards the pair and leaves the published values alone.
        if (is_pressed) begin
          x_d     = x_shift_q;
          y_d     = y_shift_q;
          valid_d = 1'b1;
        end
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: every register here, including the shift registers, is reset so
      // a reset mid-frame leaves no partial result behind.
      state_q   <= IDLE;
      timer_q   <= '0;
      pending_q <= 1'b0;
      div_q     <= '0;
      half_q    <= 1'b0;
      period_q  <= '0;
      x_shift_q <= '0;
      y_shift_q <= '0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      x_q       <= '0;
      y_q       <= '0;
      valid_q   <= 1'b0;
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      pending_q <= pending_d;
      div_q     <= div_d;
      half_q    <= half_d;
      period_q  <= period_d;
      x_shift_q <= x_shift_d;
      y_shift_q <= y_shift_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      cs_n_q    <= cs_n_d;
      x_q       <= x_d;
      y_q       <= y_d;
      valid_q   <= valid_d;
      sync1_q   <= pen_irq_n;
      sync2_q   <= sync1_q;
    end
  end

  assign spi_sclk    = sclk_q;
  assign spi_mosi    = mosi_q;
  assign spi_cs_n    = cs_n_q;
  assign x_touch     = x_q;
  assign y_touch     = y_q;
  assign touch_valid = valid_q;
  assign isPressed   = is_pressed;

endmodule

// File: tb/tb_touch_coord_reader.sv
// -----------------------------------------------------------------------------
// Testbench for touch_coord_reader (CLK_DIV=2, SAMPLE_PERIOD=400).
// A behavioural touch-controller model decodes the command byte from MOSI and
// answers with the X or Y value on MISO; a bus monitor records frame, gap and
// pulse statistics that the scenario tasks compare against expectations.
// -----------------------------------------------------------------------------
module tb_touch_coord_reader;

  localparam int CD  = 2;
  localparam int SP  = 400;
  localparam int LAT = 96 * CD + CD + 1;

  logic        clock     = 1'b0;
  logic        reset     = 1'b1;
  logic        pen_irq_n = 1'b1;
  logic        spi_miso  = 1'b0;
  logic        spi_sclk;
  logic        spi_mosi;
  logic        spi_cs_n;
  logic [11:0] x_touch;
  logic [11:0] y_touch;
  logic        touch_valid;
  logic        isPressed;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  touch_coord_reader #(
    .CLK_DIV      (CD),
    .SAMPLE_PERIOD(SP)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .pen_irq_n  (pen_irq_n),
    .spi_miso   (spi_miso),
    .spi_sclk   (spi_sclk),
    .spi_mosi   (spi_mosi),
    .spi_cs_n   (spi_cs_n),
    .x_touch    (x_touch),
    .y_touch    (y_touch),
    .touch_valid(touch_valid),
    .isPressed  (isPressed)
  );

  // Values the controller model returns; written only by the scenario tasks.
  logic [11:0] x_model = '0;
  logic [11:0] y_model = '0;

  // ---------------------------------------------------------------------------
  // Bus monitor + controller model, sampled 1 time unit after each rising edge.
  // ---------------------------------------------------------------------------
  int          cyc            = 0;
  int          cs_falls       = 0;
  int          per            = 0;
  int          rises          = 0;
  int          gap_cnt        = 0;
  int          cs_low_cycles  = 0;
  int          total_rises    = 0;
  int          valid_pulses   = 0;
  int          valid_high     = 0;
  int          last_valid_cyc = 0;
  int          prev_valid_cyc = 0;
  int          last_lat       = 0;
  int          pair_start_cyc = 0;
  logic [7:0]  cmd            = '0;
  logic [11:0] val;
  logic        prev_cs        = 1'b1;
  logic        prev_sc        = 1'b0;
  logic        prev_v         = 1'b0;
  int          fall_q[$];
  int          rises_q[$];
  logic [7:0]  cmd_q[$];
  int          gap_q[$];

  always @(posedge clock) begin
    #1;
    cyc = cyc + 1;
    if (prev_cs && !spi_cs_n) begin
      cs_falls++;
      fall_q.push_back(cyc);
      gap_q.push_back(gap_cnt);
      per   = 0;
      rises = 0;
      cmd   = '0;
    end
    if (!prev_cs && spi_cs_n) begin
      rises_q.push_back(rises);
      cmd_q.push_back(cmd);
      gap_cnt = 0;
    end
    if (spi_cs_n) gap_cnt++;
    else          cs_low_cycles++;
    if (!prev_sc && spi_sclk) begin
      total_rises++;
      if (!spi_cs_n) begin
        rises++;
        if (per < 8) cmd = {cmd[6:0], spi_mosi};
      end
    end
    if (prev_sc && !spi_sclk && !spi_cs_n) per++;
    if (!spi_cs_n) begin
      if (per >= 9 && per <= 20) begin
        val      = (cmd == 8'hD0) ? x_model : (cmd == 8'h90) ? y_model : 12'h000;
        spi_miso = val[20 - per];
      end else begin
        spi_miso = 1'($urandom);
      end
    end
    if (touch_valid) begin
      valid_high++;
      if (!prev_v) begin
        valid_pulses++;
        prev_valid_cyc = last_valid_cyc;
        last_valid_cyc = cyc;
        pair_start_cyc = (fall_q.size() >= 2) ? fall_q[fall_q.size() - 2] : 0;
        last_lat       = cyc - pair_start_cyc;
      end
    end
    prev_cs = spi_cs_n;
    prev_sc = spi_sclk;
    prev_v  = touch_valid;
  end

  // ---------------------------------------------------------------------------
  // Wait helpers (bounded)
  // ---------------------------------------------------------------------------
  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_pulse(input int budget, output bit ok);
    int start;
    start = valid_pulses;
    ok    = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (valid_pulses > start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_falls(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (cs_falls >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset     = 1'b1;
    pen_irq_n = 1'b1;
    wait_cycles(5);
    checks++; if (spi_cs_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n got %b exp 1", spi_cs_n); end
    checks++; if (spi_sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk got %b exp 0", spi_sclk); end
    checks++; if (spi_mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi got %b exp 0", spi_mosi); end
    checks++; if (x_touch !== 12'd0) begin errors++; $display("FAIL reset_x got %0d exp 0", x_touch); end
    checks++; if (y_touch !== 12'd0) begin errors++; $display("FAIL reset_y got %0d exp 0", y_touch); end
    checks++; if (touch_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", touch_valid); end
    checks++; if (isPressed !== 1'b0) begin errors++; $display("FAIL reset_pressed got %b exp 0", isPressed); end
    reset = 1'b0;
  endtask

  task automatic test_idle();
    int low0, r0, v0;
    pen_irq_n = 1'b1;
    low0 = cs_low_cycles;
    r0   = total_rises;
    v0   = valid_high;
    wait_cycles(2000);
    checks++; if (cs_low_cycles - low0 != 0) begin errors++; $display("FAIL idle_cs_low got %0d cycles exp 0", cs_low_cycles - low0); end
    checks++; if (total_rises - r0 != 0) begin errors++; $display("FAIL idle_sclk_rises got %0d exp 0", total_rises - r0); end
    checks++; if (valid_high - v0 != 0) begin errors++; $display("FAIL idle_valid got %0d exp 0", valid_high - v0); end
    checks++; if (isPressed !== 1'b0) begin errors++; $display("FAIL idle_pressed got %b exp 0", isPressed); end
  endtask

  task automatic test_basic();
    bit ok;
    int qi, gi;
    x_model   = 12'd700;
    y_model   = 12'd895;
    qi        = cmd_q.size();
    gi        = gap_q.size();
    pen_irq_n = 1'b0;
    wait_pulse(2 * SP + LAT, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_timeout got no pulse exp pulse"); end
    checks++; if (x_touch !== 12'd700) begin errors++; $display("FAIL basic_x got %0d exp 700", x_touch); end
    checks++; if (y_touch !== 12'd895) begin errors++; $display("FAIL basic_y got %0d exp 895", y_touch); end
    checks++; if (last_lat != LAT) begin errors++; $display("FAIL basic_latency got %0d exp %0d", last_lat, LAT); end
    @(negedge clock);
    checks++; if (touch_valid !== 1'b0) begin errors++; $display("FAIL basic_pulse_width got %b exp 0", touch_valid); end
    checks++; if (valid_high != valid_pulses) begin errors++; $display("FAIL basic_valid_cycles got %0d exp %0d", valid_high, valid_pulses); end
    checks++;
    if (cmd_q.size() < qi + 2 || gap_q.size() < gi + 2) begin
      errors++; $display("FAIL basic_frames got %0d frames exp 2", cmd_q.size() - qi);
    end else begin
      if (cmd_q[qi] !== 8'hD0) begin errors++; $display("FAIL basic_cmd_x got %h exp d0", cmd_q[qi]); end
      checks++; if (cmd_q[qi+1] !== 8'h90) begin errors++; $display("FAIL basic_cmd_y got %h exp 90", cmd_q[qi+1]); end
      checks++; if (rises_q[qi] != 24) begin errors++; $display("FAIL basic_rises_x got %0d exp 24", rises_q[qi]); end
      checks++; if (rises_q[qi+1] != 24) begin errors++; $display("FAIL basic_rises_y got %0d exp 24", rises_q[qi+1]); end
      checks++; if (gap_q[gi+1] != CD) begin errors++; $display("FAIL basic_gap got %0d exp %0d", gap_q[gi+1], CD); end
    end
  endtask

  task automatic test_release();
    bit ok;
    int pv, ri;
    x_model = 12'd100;
    y_model = 12'd200;
    wait_falls(cs_falls + 2, 2 * SP, ok);
    checks++; if (!ok) begin errors++; $display("FAIL release_timeout got no CONV_Y exp CONV_Y"); end
    wait_cycles(20);
    pen_irq_n = 1'b1;
    pv = valid_pulses;
    ri = rises_q.size();
    wait_cycles(300);
    checks++; if (valid_pulses != pv) begin errors++; $display("FAIL release_no_valid got %0d pulses exp 0", valid_pulses - pv); end
    checks++; if (x_touch !== 12'd700) begin errors++; $display("FAIL release_x_held got %0d exp 700", x_touch); end
    checks++; if (y_touch !== 12'd895) begin errors++; $display("FAIL release_y_held got %0d exp 895", y_touch); end
    checks++; if (isPressed !== 1'b0) begin errors++; $display("FAIL release_pressed got %b exp 0", isPressed); end
    checks++;
    if (rises_q.size() <= ri) begin
      errors++; $display("FAIL release_frame_end got no frame end exp frame end");
    end else if (rises_q[ri] != 24) begin
      errors++; $display("FAIL release_frame_len got %0d exp 24", rises_q[ri]);
    end
  endtask

  task automatic test_periodic();
    bit          ok;
    int          f0;
    logic [11:0] xe, ye;
    pen_irq_n = 1'b0;
    for (int k = 0; k < 6; k++) begin
      xe      = 12'($urandom_range(0, 4095));
      ye      = 12'($urandom_range(0, 4095));
      x_model = xe;
      y_model = ye;
      f0      = cs_falls;
      wait_pulse(2 * SP + LAT, ok);
      checks++; if (!ok) begin errors++; $display("FAIL periodic_timeout[%0d] got no pulse exp pulse", k); end
      checks++; if (x_touch !== xe) begin errors++; $display("FAIL periodic_x[%0d] got %0d exp %0d", k, x_touch, xe); end
      checks++; if (y_touch !== ye) begin errors++; $display("FAIL periodic_y[%0d] got %0d exp %0d", k, y_touch, ye); end
      checks++; if (last_lat != LAT) begin errors++; $display("FAIL periodic_latency[%0d] got %0d exp %0d", k, last_lat, LAT); end
      if (k >= 1) begin
        checks++; if (cs_falls - f0 != 2) begin errors++; $display("FAIL periodic_frames[%0d] got %0d exp 2", k, cs_falls - f0); end
      end
      if (k >= 2) begin
        checks++;
        if (last_valid_cyc - prev_valid_cyc != SP) begin
          errors++; $display("FAIL periodic_interval[%0d] got %0d exp %0d", k, last_valid_cyc - prev_valid_cyc, SP);
        end
      end
    end
  endtask

  task automatic test_reset_midframe();
    bit          ok, found;
    int          rel;
    logic [11:0] xe, ye;
    pen_irq_n = 1'b0;
    wait_falls(cs_falls + 1, 2 * SP, ok);
    checks++; if (!ok) begin errors++; $display("FAIL midreset_timeout got no CONV_X exp CONV_X"); end
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (rises == 12 && !spi_sclk && !spi_cs_n) begin
        found = 1'b1;
        break;
      end
      @(negedge clock);
    end
    checks++; if (!found) begin errors++; $display("FAIL midreset_period12 got not reached exp reached"); end
    xe      = 12'($urandom_range(0, 4095));
    ye      = 12'($urandom_range(0, 4095));
    x_model = xe;
    y_model = ye;
    reset   = 1'b1;
    @(negedge clock);
    checks++; if (spi_cs_n !== 1'b1) begin errors++; $display("FAIL midreset_cs_n got %b exp 1", spi_cs_n); end
    checks++; if (spi_sclk !== 1'b0) begin errors++; $display("FAIL midreset_sclk got %b exp 0", spi_sclk); end
    checks++; if (x_touch !== 12'd0) begin errors++; $display("FAIL midreset_x got %0d exp 0", x_touch); end
    checks++; if (y_touch !== 12'd0) begin errors++; $display("FAIL midreset_y got %0d exp 0", y_touch); end
    checks++; if (touch_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid got %b exp 0", touch_valid); end
    checks++; if (isPressed !== 1'b0) begin errors++; $display("FAIL midreset_pressed got %b exp 0", isPressed); end
    wait_cycles(2);
    reset = 1'b0;
    rel   = cyc;
    wait_pulse(SP + LAT + 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL midreset_timeout2 got no pulse exp pulse"); end
    checks++; if (x_touch !== xe) begin errors++; $display("FAIL midreset_x2 got %0d exp %0d", x_touch, xe); end
    checks++; if (y_touch !== ye) begin errors++; $display("FAIL midreset_y2 got %0d exp %0d", y_touch, ye); end
    checks++; if (last_lat != LAT) begin errors++; $display("FAIL midreset_latency got %0d exp %0d", last_lat, LAT); end
    checks++;
    if (pair_start_cyc - rel != SP + 1) begin
      errors++; $display("FAIL midreset_first_start got %0d exp %0d", pair_start_cyc - rel, SP + 1);
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_basic();
    test_release();
    test_periodic();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
